spi_slv_reg_if: RTL and testbench
=================================

# spi_slv_reg_if

SPI slave front end that converts serial SPI frames into single-cycle register-bus transactions (write enable, read enable, address, write data) for the register bank, and returns read data on MISO. It sits between the chip SPI pads and the register bank. SPI inputs are oversampled and synchronised into the single system clock domain, so there is no SPI-clock domain inside the block.

## Interface
Parameters:
- AW, 8, register address width
- DW, 8, register data width
- SYNC_STAGES, 2, synchroniser depth for sclk/csb/mosi (≥2)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- i_spi_csb  in  1  chip select, active-low
- i_spi_mosi  in  1  serial data in, MSB first
- o_spi_miso  out  1  serial data out, MSB first
- o_spi_miso_oe  out  1  MISO pad output enable
- o_wen  out  1  register write strobe, one cycle
- o_ren  out  1  register read strobe, one cycle
- o_addr  out  AW  register address
- o_wdata  out  DW  register write data
- i_rdata  in  DW  OR-combined read data from the bank, valid in the o_ren cycle
- o_busy  out  1  frame in progress
- o_frame_err  out  1  one-cycle pulse on an aborted or bad frame

## Operation
- Frame layout: RW bit (1 = read, 0 = write), then AW address bits, then DW data bits. FRAME_LEN = 1+AW+DW, plus 1 parity bit when configured.
- sclk, csb and mosi pass through SYNC_STAGES flops. Edges are detected on synchronised sclk. MOSI is sampled on the rising edge. MISO changes on the falling edge.
- States:
  - WAIT_CSB_HIGH (reset state): leave when synchronised csb=1 → IDLE.
  - IDLE: csb falling → HDR. o_busy=1 from this point.
  - HDR: shift RW and address. After bit 1+AW: read → assert o_ren for one cycle with o_addr valid, load i_rdata into the TX shifter, go to RD_DATA; write → WR_DATA.
  - RD_DATA: drive MISO from the TX shifter. o_spi_miso_oe=1. Shift on each falling edge. After DW rising edges → DONE.
  - WR_DATA: shift DW bits. On the last bit (or the parity bit), assert o_wen for one cycle with o_addr/o_wdata valid → DONE.
  - DONE: ignore further sclk edges. csb rising → IDLE.
- Abort: csb rises in HDR/RD_DATA/WR_DATA → no o_wen, o_frame_err pulse, → IDLE. A read already strobed is not undone.
- o_addr/o_wdata hold their last value between frames.
- Bit counter width: clog2(FRAME_LEN+1). It saturates at FRAME_LEN.
- Reset while a frame is in progress: all outputs return to reset values, state goes to WAIT_CSB_HIGH, and the rest of the current frame is ignored.

## Timing
- Reset values: o_wen=0, o_ren=0, o_addr=0, o_wdata=0, o_spi_miso=0, o_spi_miso_oe=0, o_busy=0, o_frame_err=0.
- Input latency: SYNC_STAGES+1 i_clk cycles from pad edge to internal edge pulse.
- sclk high and low phases must each be ≥ SYNC_STAGES+2 i_clk periods. csb high time between frames must be ≥ SYNC_STAGES+2 periods.
- o_ren fires 1 cycle after the internal rising edge of the last address bit. MISO bit DW-1 is driven on the next falling edge.
- o_wen fires 1 cycle after the internal rising edge of the final bit.
- If csb rise and the final rising edge land in the same cycle, the frame is complete: the write occurs and there is no error.
- o_busy drops 1 cycle after the internal csb rise.

## Configuration
- SPI_SLV_PARITY_EN defined: write frames carry one extra even-parity bit covering RW+address+data.
  - Mismatch → no o_wen, o_frame_err pulse.
  - Read frames return DW data bits, then the parity bit of the data on MISO.
- SPI_SLV_PARITY_EN undefined: no parity bit, FRAME_LEN = 1+AW+DW, and the parity logic is absent.

## Structure
- Package spi_slv_pkg holds:
  - the state enum (WAIT_CSB_HIGH, IDLE, HDR, RD_DATA, WR_DATA, DONE)
  - the RW encoding constants
  - a FRAME_LEN function of AW/DW
- Sub-module spi_in_sync: parameterised SYNC_STAGES flop chain, instantiated once per SPI input, reset to 1 for csb and 0 for sclk/mosi.

## Test plan
- Write (AW=DW=8): frame 0,0x12,0x5A → exactly one o_wen, o_addr=0x12, o_wdata=0x5A, o_ren never asserted.
- Read: frame 1,0x34 with i_rdata=0xA5 → one o_ren with o_addr=0x34; MISO reads 1,0,1,0,0,1,0,1; oe=1 only during the data phase.
- Abort: csb raised after 10 bits of a write → no o_wen, one o_frame_err pulse, o_busy=0.
- Reset mid-read with csb held low → outputs at reset values; the next frame is ignored until csb goes high, then a write of 0x77 to 0x01 succeeds.
- Back-to-back: write then read with minimum csb-high gap → both transactions correct, one strobe each.
- With SPI_SLV_PARITY_EN: write 0x03→0x10 with a wrong parity bit → no o_wen, o_frame_err=1 for one cycle; with correct parity → o_wen asserted.

Source files
------------

// File: rtl/spi_slv_pkg.sv
// Shared state type, RW encoding and frame-length helper for the SPI slave register front end.
// Define SPI_SLV_PARITY_EN to append an even-parity bit to every frame.
package spi_slv_pkg;

    typedef enum logic [2:0] {
        WAIT_CSB_HIGH,
        IDLE,
        HDR,
        RD_DATA,
        WR_DATA,
        DONE
    } state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

`ifdef SPI_SLV_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

    function automatic int unsigned frame_len(input int unsigned aw, input int unsigned dw);
        return 1 + aw + dw + PAR_BITS;
    endfunction

endpackage

// File: rtl/spi_slv_reg_if_if.sv
// SPI pad and register-bus signals of spi_slv_reg_if; slave is the DUT view, master the pad/bank view.
interface spi_slv_reg_if_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          i_spi_sclk;
    logic          i_spi_csb;
    logic          i_spi_mosi;
    logic          o_spi_miso;
    logic          o_spi_miso_oe;
    logic          o_wen;
    logic          o_ren;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;
    logic [DW-1:0] i_rdata;
    logic          o_busy;
    logic          o_frame_err;

    modport slave (
        input  i_spi_sclk, i_spi_csb, i_spi_mosi, i_rdata,
        output o_spi_miso, o_spi_miso_oe, o_wen, o_ren, o_addr, o_wdata, o_busy, o_frame_err
    );

    modport master (
        output i_spi_sclk, i_spi_csb, i_spi_mosi, i_rdata,
        input  o_spi_miso, o_spi_miso_oe, o_wen, o_ren, o_addr, o_wdata, o_busy, o_frame_err
    );
endinterface

// File: rtl/spi_slv_reg_if_sync.sv
// spi_in_sync: SYNC_STAGES-deep synchroniser for one SPI pad input, reset to RST_VAL.
module spi_in_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [SYNC_STAGES-1:0] chain_q, chain_d;

    always_comb chain_d = {chain_q[SYNC_STAGES-2:0], i_d};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) chain_q <= {SYNC_STAGES{RST_VAL}};
        else       chain_q <= chain_d;
    end

    assign o_q = chain_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_slv_reg_if.sv
// SPI mode-0 slave turning oversampled frames {RW, addr, data[, parity]} into one-cycle register strobes.
// Optional even parity per frame is enabled by defining SPI_SLV_PARITY_EN.
module spi_slv_reg_if
    import spi_slv_pkg::*;
#(
    parameter int unsigned AW          = 8,
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic             i_clk,
    input logic             i_rst,
    spi_slv_reg_if_if.slave bus
);
    localparam int unsigned FRAME_LEN = frame_len(AW, DW);
    localparam int unsigned CW        = $clog2(FRAME_LEN + 1);
    localparam int unsigned SW        = FRAME_LEN;
    localparam int unsigned TXW       = DW + PAR_BITS;
    localparam int unsigned SETTLE    = SYNC_STAGES + 1;

    logic sclk_s, csb_s, mosi_s;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(bus.i_spi_sclk), .o_q(sclk_s));
    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(bus.i_spi_csb), .o_q(csb_s));
    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(bus.i_spi_mosi), .o_q(mosi_s));

    logic sclk_q, sclk_d, csb_q, csb_d, mosi_q, mosi_d;
    logic sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d;
    logic csb_rise_q, csb_rise_d, csb_fall_q, csb_fall_d;

    always_comb begin
        sclk_d      = sclk_s;
        csb_d       = csb_s;
        mosi_d      = mosi_s;
        sclk_rise_d = sclk_s & ~sclk_q;
        sclk_fall_d = ~sclk_s & sclk_q;
        csb_rise_d  = csb_s & ~csb_q;
        csb_fall_d  = ~csb_s & csb_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_q      <= 1'b0;
            csb_q       <= 1'b1;
            mosi_q      <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            csb_rise_q  <= 1'b0;
            csb_fall_q  <= 1'b0;
        end else begin
            sclk_q      <= sclk_d;
            csb_q       <= csb_d;
            mosi_q      <= mosi_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            csb_rise_q  <= csb_rise_d;
            csb_fall_q  <= csb_fall_d;
        end
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [SW-2:0]   sh_q, sh_d;
    logic [SW-1:0]   sh_shift;
    logic [TXW-1:0]  tx_q, tx_d, tx_load;
    logic            miso_q, miso_d, wen_q, wen_d, ren_q, ren_d, err_q, err_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            hdr_end, last_bit, last_rise, frame_ok;

    always_comb begin
        sh_shift  = {sh_q, mosi_q};
        cnt_inc   = (cnt_q == CW'(FRAME_LEN)) ? cnt_q : cnt_q + CW'(1);
        hdr_end   = (cnt_q == CW'(AW));
        last_bit  = (cnt_q == CW'(FRAME_LEN - 1));
        last_rise = sclk_rise_q & last_bit;
`ifdef SPI_SLV_PARITY_EN
        frame_ok  = (sh_shift[SW-1] == RW_WRITE) && !(^sh_shift);
        tx_load   = {bus.i_rdata, ^bus.i_rdata};
`else
        frame_ok  = (sh_shift[SW-1] == RW_WRITE);
        tx_load   = bus.i_rdata;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= WAIT_CSB_HIGH;
        else       state_q <= state_d;
    end

    // A final rising edge that coincides with csb rising completes the frame rather than aborting it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_CSB_HIGH: if (csb_q && cnt_q >= CW'(SETTLE)) state_d = IDLE;
            IDLE:          if (csb_fall_q) state_d = HDR;
            HDR: begin
                if (csb_rise_q)                 state_d = IDLE;
                else if (sclk_rise_q && hdr_end) state_d = (sh_shift[AW] == RW_READ) ? RD_DATA : WR_DATA;
            end
            RD_DATA, WR_DATA: begin
                if (last_rise)       state_d = csb_rise_q ? IDLE : DONE;
                else if (csb_rise_q) state_d = IDLE;
            end
            DONE:          if (csb_rise_q) state_d = IDLE;
            default:       state_d = WAIT_CSB_HIGH;
        endcase
    end

    // The counter doubles as a settle timer in WAIT_CSB_HIGH so the reset value of the csb chain is never trusted.
    always_comb begin
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        miso_d  = miso_q;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
        err_d   = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            WAIT_CSB_HIGH: cnt_d = cnt_inc;
            IDLE: begin
                cnt_d  = '0;
                miso_d = 1'b0;
            end
            HDR: begin
                if (csb_rise_q) begin
                    err_d = 1'b1;
                end else if (sclk_rise_q) begin
                    sh_d  = sh_shift[SW-2:0];
                    cnt_d = cnt_inc;
                    if (hdr_end && sh_shift[AW] == RW_READ) begin
                        ren_d  = 1'b1;
                        addr_d = sh_shift[AW-1:0];
                    end
                end
            end
            RD_DATA: begin
                if (ren_q) tx_d = tx_load;
                if (sclk_fall_q) begin
                    miso_d = tx_q[TXW-1];
                    tx_d   = {tx_q[TXW-2:0], 1'b0};
                end
                if (sclk_rise_q) cnt_d = cnt_inc;
                if (csb_rise_q && !last_rise) err_d = 1'b1;
            end
            WR_DATA: begin
                if (sclk_rise_q) begin
                    sh_d  = sh_shift[SW-2:0];
                    cnt_d = cnt_inc;
                end
                if (last_rise) begin
                    if (frame_ok) begin
                        wen_d   = 1'b1;
                        addr_d  = sh_shift[PAR_BITS+DW +: AW];
                        wdata_d = sh_shift[PAR_BITS +: DW];
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (csb_rise_q) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            sh_q    <= '0;
            tx_q    <= '0;
            miso_q  <= 1'b0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            miso_q  <= miso_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        bus.o_spi_miso    = miso_q;
        bus.o_spi_miso_oe = (state_q == RD_DATA);
        bus.o_wen         = wen_q;
        bus.o_ren         = ren_q;
        bus.o_addr        = addr_q;
        bus.o_wdata       = wdata_q;
        bus.o_busy        = state_q inside {HDR, RD_DATA, WR_DATA, DONE};
        bus.o_frame_err   = err_q;
    end
endmodule

// File: tb/tb_spi_slv_reg_if.sv
// Directed bench for spi_slv_reg_if: write, read, abort, mid-frame reset and back-to-back frames.
// The parity steps are built only when SPI_SLV_PARITY_EN is defined.
module tb_spi_slv_reg_if;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned SS = 2;
    localparam int unsigned H  = 6;
`ifdef SPI_SLV_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned FL = 1 + AW + DW + PB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] rd_val = '0;
    always #5 clk = ~clk;

    spi_slv_reg_if_if #(.AW(AW), .DW(DW)) bus ();

    spi_slv_reg_if #(.AW(AW), .DW(DW), .SYNC_STAGES(SS)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    // Register bank model: read data only on the bus during the read strobe.
    always_comb bus.i_rdata = bus.o_ren ? rd_val : '0;

    int            checks = 0, failures = 0;
    int            wen_cnt = 0, ren_cnt = 0, err_cnt = 0;
    logic [AW-1:0] wen_addr = '0, ren_addr = '0;
    logic [DW-1:0] wen_data = '0;

    always @(negedge clk) begin
        if (bus.o_wen) begin
            wen_cnt++;
            wen_addr = bus.o_addr;
            wen_data = bus.o_wdata;
        end
        if (bus.o_ren) begin
            ren_cnt++;
            ren_addr = bus.o_addr;
        end
        if (bus.o_frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FL-1:0] mk(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [AW+DW:0] core;
        core = {rw, a, d};
`ifdef SPI_SLV_PARITY_EN
        return {core, ^core};
`else
        return core;
`endif
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bits(input logic [FL-1:0] v, input int n,
                              output logic [FL-1:0] miso_v, output logic [FL-1:0] oe_v);
        miso_v = '0;
        oe_v   = '0;
        for (int i = 0; i < n; i++) begin
            bus.i_spi_mosi = v[FL-1-i];
            wait_clk(H);
            bus.i_spi_sclk = 1'b1;
            miso_v[FL-1-i] = bus.o_spi_miso;
            oe_v[FL-1-i]   = bus.o_spi_miso_oe;
            wait_clk(H);
            bus.i_spi_sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [FL-1:0] v, input int n, input int gap,
                         output logic [FL-1:0] miso_v, output logic [FL-1:0] oe_v);
        bus.i_spi_csb = 1'b0;
        wait_clk(H);
        chk("busy_mid", 32'(bus.o_busy), 32'd1);
        clock_bits(v, n, miso_v, oe_v);
        wait_clk(H);
        bus.i_spi_csb = 1'b1;
        wait_clk(gap);
    endtask

    logic [FL-1:0] mv, ov, oe_exp;
    int w0, r0, e0;

    initial begin
        bus.i_spi_sclk = 1'b0;
        bus.i_spi_csb  = 1'b1;
        bus.i_spi_mosi = 1'b0;
        oe_exp = '0;
        oe_exp[DW+PB-1:0] = '1;

        wait_clk(3);
        chk("rst_wen",   32'(bus.o_wen), 32'd0);
        chk("rst_ren",   32'(bus.o_ren), 32'd0);
        chk("rst_addr",  32'(bus.o_addr), 32'd0);
        chk("rst_wdata", 32'(bus.o_wdata), 32'd0);
        chk("rst_miso",  32'(bus.o_spi_miso), 32'd0);
        chk("rst_oe",    32'(bus.o_spi_miso_oe), 32'd0);
        chk("rst_busy",  32'(bus.o_busy), 32'd0);
        chk("rst_err",   32'(bus.o_frame_err), 32'd0);
        rst = 1'b0;
        wait_clk(10);

        // Write 0x5A to 0x12
        w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
        frame(mk(1'b0, 8'h12, 8'h5A), FL, 10, mv, ov);
        chk("wr_wen_cnt", wen_cnt - w0, 32'd1);
        chk("wr_addr",    32'(wen_addr), 32'h12);
        chk("wr_data",    32'(wen_data), 32'h5A);
        chk("wr_ren_cnt", ren_cnt - r0, 32'd0);
        chk("wr_err_cnt", err_cnt - e0, 32'd0);
        chk("wr_busy",    32'(bus.o_busy), 32'd0);
        chk("wr_hold",    32'(bus.o_addr), 32'h12);

        // Read 0x34, bank returns 0xA5
        rd_val = 8'hA5;
        w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
        frame(mk(1'b1, 8'h34, 8'h00), FL, 10, mv, ov);
        chk("rd_ren_cnt", ren_cnt - r0, 32'd1);
        chk("rd_addr",    32'(ren_addr), 32'h34);
        chk("rd_miso",    32'(mv[PB +: DW]), 32'hA5);
        chk("rd_oe",      32'(ov), 32'(oe_exp));
        chk("rd_wen_cnt", wen_cnt - w0, 32'd0);
        chk("rd_err_cnt", err_cnt - e0, 32'd0);
        chk("rd_oe_after", 32'(bus.o_spi_miso_oe), 32'd0);
        chk("rd_wdata_hold", 32'(bus.o_wdata), 32'h5A);
`ifdef SPI_SLV_PARITY_EN
        chk("rd_parity",  32'(mv[0]), 32'd0);
`endif

        // Abort a write after 10 bits
        w0 = wen_cnt; e0 = err_cnt;
        frame(mk(1'b0, 8'h12, 8'hFF), 10, 10, mv, ov);
        chk("ab_wen_cnt", wen_cnt - w0, 32'd0);
        chk("ab_err_cnt", err_cnt - e0, 32'd1);
        chk("ab_busy",    32'(bus.o_busy), 32'd0);
        chk("ab_addr",    32'(bus.o_addr), 32'h34);
        chk("ab_wdata",   32'(bus.o_wdata), 32'h5A);

        // Reset in the middle of a read while csb stays low
        rd_val = 8'hC3;
        bus.i_spi_csb = 1'b0;
        wait_clk(H);
        clock_bits(mk(1'b1, 8'h56, 8'h00), 12, mv, ov);
        rst = 1'b1;
        wait_clk(2);
        chk("mr_addr",  32'(bus.o_addr), 32'd0);
        chk("mr_wdata", 32'(bus.o_wdata), 32'd0);
        chk("mr_oe",    32'(bus.o_spi_miso_oe), 32'd0);
        chk("mr_busy",  32'(bus.o_busy), 32'd0);
        chk("mr_miso",  32'(bus.o_spi_miso), 32'd0);
        rst = 1'b0;
        w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
        clock_bits(mk(1'b1, 8'h56, 8'h00), FL - 12, mv, ov);
        clock_bits(mk(1'b0, 8'h01, 8'h77), FL, mv, ov);
        chk("mr_ign_wen",  wen_cnt - w0, 32'd0);
        chk("mr_ign_ren",  ren_cnt - r0, 32'd0);
        chk("mr_ign_err",  err_cnt - e0, 32'd0);
        chk("mr_ign_busy", 32'(bus.o_busy), 32'd0);
        bus.i_spi_csb = 1'b1;
        wait_clk(10);
        frame(mk(1'b0, 8'h01, 8'h77), FL, 10, mv, ov);
        chk("mr_wen_cnt", wen_cnt - w0, 32'd1);
        chk("mr_wr_addr", 32'(wen_addr), 32'h01);
        chk("mr_wr_data", 32'(wen_data), 32'h77);

        // Back-to-back write then read with the minimum csb-high gap
        rd_val = 8'h3C;
        w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;
        frame(mk(1'b0, 8'h21, 8'h5C), FL, SS + 2, mv, ov);
        frame(mk(1'b1, 8'h43, 8'h00), FL, 10, mv, ov);
        chk("bb_wen_cnt", wen_cnt - w0, 32'd1);
        chk("bb_ren_cnt", ren_cnt - r0, 32'd1);
        chk("bb_err_cnt", err_cnt - e0, 32'd0);
        chk("bb_wr_addr", 32'(wen_addr), 32'h21);
        chk("bb_wr_data", 32'(wen_data), 32'h5C);
        chk("bb_rd_addr", 32'(ren_addr), 32'h43);
        chk("bb_rd_miso", 32'(mv[PB +: DW]), 32'h3C);

`ifdef SPI_SLV_PARITY_EN
        // Write 0x03 to 0x10: first with the parity bit flipped, then correct
        w0 = wen_cnt; e0 = err_cnt;
        frame(mk(1'b0, 8'h10, 8'h03) ^ FL'(1), FL, 10, mv, ov);
        chk("par_bad_wen", wen_cnt - w0, 32'd0);
        chk("par_bad_err", err_cnt - e0, 32'd1);
        w0 = wen_cnt; e0 = err_cnt;
        frame(mk(1'b0, 8'h10, 8'h03), FL, 10, mv, ov);
        chk("par_ok_wen",  wen_cnt - w0, 32'd1);
        chk("par_ok_err",  err_cnt - e0, 32'd0);
        chk("par_ok_addr", 32'(wen_addr), 32'h10);
        chk("par_ok_data", 32'(wen_data), 32'h03);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
